// File: rtl/fmul_pipe.sv
// -----------------------------------------------------------------------------
// fmul_pipe -- three-stage pipelined IEEE-754 single-precision multiplier.
//
//   S1: unpack operands, biased exponent sum (e1+e2-127), sign XOR, zero detect
//   S2: 24x24 significand multiply
//   S3: normalize, round, overflow/underflow clamp, pack into y
//
// Operands with a zero exponent are flushed to zero. Exponent results <= 0
// give signed zero and results >= 255 give signed infinity. NaN/Inf inputs
// give an unspecified y, but their valid bit still flows through normally.
//
// Build option:
//   FMUL_RNE_EN  defined   -> round to nearest, ties to even
//                undefined -> truncate (round toward zero)
//   Latency and handshake are the same in both builds.
//
// Flow control: all stages advance together when the output is free or taken
// (advance = out_ready | ~out_valid). in_ready is that same signal, so a full
// pipe can still accept one request per cycle while the consumer takes one.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rstn       in   1   asynchronous active-low reset
//   x1, x2     in  32   operands {sign, exp[7:0], mant[22:0]}
//   in_valid   in   1   request present on x1/x2
//   in_ready   out  1   request accepted this cycle (when in_valid)
//   y          out 32   product
//   out_valid  out  1   y holds a result
//   out_ready  in   1   consumer takes y this cycle
// -----------------------------------------------------------------------------
module fmul_pipe (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] y,
  output logic        out_valid,
  input  logic        out_ready
);

  // The truncating build keeps only product bits [47:23] in S2; the bits
  // below never influence a truncated result.
`ifdef FMUL_RNE_EN
  localparam int PW = 48;
`else
  localparam int PW = 25;
`endif

  // Stage valid bits and output register
  logic        r_v1, r_v2, r_v3;
  logic [31:0] r_y;

  // S1 registers
  logic               r_sign1;
  logic               r_zero1;
  logic signed [9:0]  r_exp1;
  logic [23:0]        r_ma1;
  logic [23:0]        r_mb1;

  // S2 registers
  logic               r_sign2;
  logic               r_zero2;
  logic signed [9:0]  r_exp2;
  logic [PW-1:0]      r_prod2;

  // Combinational
  logic               w_advance;
  logic [7:0]         w_e1, w_e2;
  logic signed [9:0]  w_exp_sum;
  logic [PW-1:0]      w_prod;
  logic               w_carry;
  logic [22:0]        w_frac;
  logic               w_round_up;
  logic [23:0]        w_sig;
  logic signed [9:0]  w_exp_n;
  logic [31:0]        w_y;
`ifdef FMUL_RNE_EN
  logic               w_guard;
  logic               w_sticky;
`endif

  assign w_advance = out_ready | ~r_v3;
  assign in_ready  = w_advance;
  assign out_valid = r_v3;
  assign y         = r_y;

  // ---------------------------------------------------------------- S1 ----
  assign w_e1 = x1[30:23];
  assign w_e2 = x2[30:23];

  // 10-bit signed so that both underflow (<= 0) and overflow (>= 255) are
  // visible after normalization and rounding add their increments.
  assign w_exp_sum = $signed({2'b00, w_e1}) + $signed({2'b00, w_e2}) - 10'sd127;

  // ---------------------------------------------------------------- S2 ----
`ifdef FMUL_RNE_EN
  assign w_prod = 48'(r_ma1) * 48'(r_mb1);
`else
  assign w_prod = 25'((48'(r_ma1) * 48'(r_mb1)) >> 23);
`endif

  // ---------------------------------------------------------------- S3 ----
  // NOTE: every signal written here gets a value on every path through the
  // block; a path that skipped one would infer a latch.
  always_comb begin
    w_carry = r_prod2[PW-1];
`ifdef FMUL_RNE_EN
    w_frac     = w_carry ? r_prod2[46:24] : r_prod2[45:23];
    w_guard    = w_carry ? r_prod2[23]    : r_prod2[22];
    w_sticky   = w_carry ? (|r_prod2[22:0]) : (|r_prod2[21:0]);
    w_round_up = w_guard & (w_sticky | w_frac[0]);
`else
    w_frac     = w_carry ? r_prod2[23:1] : r_prod2[22:0];
    w_round_up = 1'b0;
`endif
    // An all-ones fraction that rounds up carries into bit 23; the fraction
    // field is then zero and the exponent gains one more.
    w_sig   = {1'b0, w_frac} + {23'd0, w_round_up};
    w_exp_n = r_exp2 + $signed({9'd0, w_carry}) + $signed({9'd0, w_sig[23]});

    if (r_zero2 || (w_exp_n <= 10'sd0)) begin
      w_y = {r_sign2, 31'd0};
    end else if (w_exp_n >= 10'sd255) begin
      w_y = {r_sign2, 8'hFF, 23'd0};
    end else begin
      w_y = {r_sign2, w_exp_n[7:0], w_sig[22:0]};
    end
  end

  // ------------------------------------------------------ control + y ----
  // NOTE: sequential state uses non-blocking assignments so each stage sees
  // the previous stage's value from before the edge, not the freshly
  // written one.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
      r_y  <= 32'h0;
    end else if (w_advance) begin
      r_v1 <= in_valid;
      r_v2 <= r_v1;
      r_v3 <= r_v2;
      r_y  <= w_y;
    end
  end

  // ------------------------------------------------------ datapath -------
  // NOTE: datapath registers carry no reset; their contents are only ever
  // observed behind a valid bit, which is reset.
  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_sign1 <= x1[31] ^ x2[31];
      r_zero1 <= (w_e1 == 8'd0) | (w_e2 == 8'd0);
      r_exp1  <= w_exp_sum;
      r_ma1   <= {1'b1, x1[22:0]};
      r_mb1   <= {1'b1, x2[22:0]};

      r_sign2 <= r_sign1;
      r_zero2 <= r_zero1;
      r_exp2  <= r_exp1;
      r_prod2 <= w_prod;
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// -----------------------------------------------------------------------------
// tb_fmul_pipe -- directed self-checking bench for fmul_pipe.
//
// Inputs change 2 time units after a rising edge; outputs and handshakes are
// sampled on the falling edge. A monitor records every accepted request's
// hand-computed product in a queue and compares each delivered y in order.
// Respects FMUL_RNE_EN for the one vector whose result depends on rounding.
// -----------------------------------------------------------------------------
module tb_fmul_pipe;

  logic        clk;
  logic        rstn;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] y;
  logic        out_valid;
  logic        out_ready;

  fmul_pipe dut (
    .clk       (clk),
    .rstn      (rstn),
    .x1        (x1),
    .x2        (x2),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .y         (y),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 1.0000001 * 1.5: exact halfway between two representable values.
`ifdef FMUL_RNE_EN
  localparam logic [31:0] TIE_ODD = 32'h3FC00002;
`else
  localparam logic [31:0] TIE_ODD = 32'h3FC00001;
`endif

  localparam int NV = 16;
  localparam logic [31:0] TA [NV] = '{
    32'h3F800000, 32'h40400000, 32'hC0000000, 32'h3FC00000,
    32'h3F800001, 32'h3FFFFFFF, 32'h3F800001, 32'h3F800003,
    32'hBF800000, 32'h3DCCCCCD, 32'h7F000000, 32'h00800000,
    32'h80000000, 32'h7F400000, 32'h00800000, 32'hC0000000
  };
  localparam logic [31:0] TB [NV] = '{
    32'h40000000, 32'h40A00000, 32'h40400000, 32'h3FC00000,
    32'h3F800001, 32'h3FFFFFFF, 32'h3FC00000, 32'h3FC00000,
    32'hBF800000, 32'h41200000, 32'h40000000, 32'h3F000000,
    32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h00000000
  };
  localparam logic [31:0] TE [NV] = '{
    32'h40000000, 32'h41700000, 32'hC0C00000, 32'h40100000,
    32'h3F800002, 32'h407FFFFE, TIE_ODD,      32'h3FC00004,
    32'h3F800000, 32'h3F800000, 32'h7F800000, 32'h00000000,
    32'h80000000, 32'h7F800000, 32'h00800000, 32'h80000000
  };

  int          n_vec = 0;
  int          n_err = 0;
  int          n_out = 0;
  int          run_len = 0;
  int          max_run = 0;
  logic [31:0] cur_exp = 32'h0;
  logic [31:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Present vector idx and hold it until accepted (bounded).
  task automatic send(input int idx);
    bit acc;
    int t;
    x1       = TA[idx];
    x2       = TB[idx];
    cur_exp  = TE[idx];
    in_valid = 1'b1;
    acc      = 1'b0;
    t        = 0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #2;
      t++;
    end
    if (!acc) check("send_timeout", {31'b0, in_ready}, 32'h1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", {31'b0, out_valid}, 32'h0);
        else check($sformatf("y_%0d", n_out), y, exp_q.pop_front());
        n_out++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn      = 1'b0;
    x1        = 32'h0;
    x2        = 32'h0;
    in_valid  = 1'b0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_y", y, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #2;
    rstn = 1'b1;

    // Latency: presented in cycle 0, out_valid only in cycle 3
    out_ready = 1'b1;
    x1        = TA[0];
    x2        = TB[0];
    cur_exp   = TE[0];
    in_valid  = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("lat_ov_c%0d", k), {31'b0, out_valid},
            (k == 3) ? 32'h1 : 32'h0);
    end
    @(posedge clk);
    #2;

    // Back-to-back 8 requests: eight consecutive results
    max_run = 0;
    for (int i = 0; i < 8; i++) send(i);
    idle(8);
    check("b2b_run", 32'(max_run), 32'd8);
    check("b2b_count", 32'(n_out), 32'd9);

    // Fill with consumer stalled, hold 5 cycles, then release
    out_ready = 1'b0;
    send(8);
    send(9);
    send(10);
    x1       = TA[11];
    x2       = TB[11];
    cur_exp  = TE[11];
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("stall_in_ready_%0d", k), {31'b0, in_ready}, 32'h0);
      check($sformatf("stall_ov_%0d", k), {31'b0, out_valid}, 32'h1);
      check($sformatf("stall_y_%0d", k), y, TE[8]);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    send(11);
    send(12);
    idle(6);
    check("stall_count", 32'(n_out), 32'd14);

    // Reset with three requests in flight
    out_ready = 1'b0;
    send(0);
    send(1);
    send(2);
    in_valid = 1'b0;
    rstn     = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    check("midrst_y", y, 32'h0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #2;
    rstn      = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("post_rst_ov_%0d", k), {31'b0, out_valid}, 32'h0);
      @(posedge clk);
      #2;
    end

    // Boundary vectors after reset
    send(13);
    send(14);
    send(15);
    idle(6);
    check("final_count", 32'(n_out), 32'd17);
    check("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
